// File: rtl/noc_serial_transmitter_if.sv
// NoC flit types and the router local-port interface
// used by the serial transmitter and its bench.
package noc_pkg;
    localparam int FLIT_DATA_WIDTH = 16;
    localparam int HDR_FREE_WIDTH = 8;

    typedef enum logic [1:0] {
        FLIT_NONE   = 2'd0,
        FLIT_HEADER = 2'd1,
        FLIT_DATA   = 2'd2,
        FLIT_TAIL   = 2'd3
    } flit_type_t;

    typedef struct packed {
        logic [3:0]                dst_x;
        logic [3:0]                dst_y;
        logic [HDR_FREE_WIDTH-1:0] free;
    } flit_hdr_t;

    typedef union packed {
        flit_hdr_t                  hdr;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } flit_payload_t;

    typedef struct packed {
        flit_type_t    flit_type;
        flit_payload_t payload;
    } flit_t;
endpackage

interface node_port;
    import noc_pkg::*;
    flit_t flit;
    logic  enable;
    logic  ack;
    logic  rej;

    modport up (
        output flit, enable,
        input  ack, rej
    );
    modport down (
        input  flit, enable,
        output ack, rej
    );
endinterface

// File: rtl/noc_serial_transmitter.sv
// Splits a wide packet into one HEADER flit plus
// LSB-first payload flits, the last typed TAIL.
module noc_serial_transmitter
    import noc_pkg::*;
#(
    parameter int PACKET_BITS  = 16,
    parameter int PADDING_BITS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  flit_hdr_t            hdr,
    input  logic [(PADDING_BITS > 0 ? PADDING_BITS : 1)-1:0] padding,
    input  logic [PACKET_BITS-1:0] packet,
    input  logic                 abort,
    output logic                 ready,
    output logic                 done,
    node_port.up                 up
);
    localparam int FW      = FLIT_DATA_WIDTH;
    localparam int N_RAW   = (PACKET_BITS + FW - 1) / FW;
    localparam int N_FLITS = (N_RAW < 1) ? 1 : N_RAW;
    localparam int CNT_W   = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam int DATA_W  = N_FLITS * FW;
    localparam int PAD_W   = (PADDING_BITS > 0) ? PADDING_BITS : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_FLITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pkt_q, pkt_d;
    logic [PAD_W-1:0]  pad_q, pad_d;
    flit_hdr_t         hdr_q, hdr_d;
    logic              done_q, done_d;

    flit_t             flit_o;
    logic              enable_o;
    flit_hdr_t         hdr_o;
    logic [FW-1:0]     slice;
    logic              accept;

    // Outputs depend on registered state only; ack/rej reach flops alone.
    always_comb begin
        slice = '0;
        for (int i = 0; i < N_FLITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                slice = pkt_q[i*FW +: FW];
            end
        end
        hdr_o = hdr_q;
        hdr_o.free = '0;
        if (PADDING_BITS > 0) begin
            hdr_o.free = HDR_FREE_WIDTH'(pad_q);
        end
        flit_o   = '0;
        enable_o = 1'b0;
        unique case (state_q)
            S_HDR: begin
                enable_o            = 1'b1;
                flit_o.flit_type    = FLIT_HEADER;
                flit_o.payload.hdr  = hdr_o;
            end
            S_DATA: begin
                enable_o            = 1'b1;
                flit_o.flit_type    = (cnt_q == LAST) ? FLIT_TAIL
                                                      : FLIT_DATA;
                flit_o.payload.data = slice;
            end
            default: ;
        endcase
    end

    assign up.flit   = flit_o;
    assign up.enable = enable_o;
    assign ready     = (state_q == S_IDLE);
    assign done      = done_q;
    assign accept    = enable_o && up.ack && !up.rej;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkt_d   = pkt_q;
        pad_d   = pad_q;
        hdr_d   = hdr_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (send && !abort) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                    pkt_d   = DATA_W'(packet);
                    pad_d   = padding;
                    hdr_d   = hdr;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any accept seen in the same cycle.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pkt_q   <= '0;
            pad_q   <= '0;
            hdr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            pad_q   <= pad_d;
            hdr_q   <= hdr_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_noc_serial_transmitter.sv
// Self-checking bench: vector table, directed corner cases,
// and a reassembling sink scoreboard with random loopback.
module tb_noc_serial_transmitter;
    import noc_pkg::*;

    localparam int NF = 3;

    logic        clk = 1'b0;
    logic        rst, send, abort;
    flit_hdr_t   hdr;
    logic [3:0]  padding;
    logic [39:0] packet;
    logic        ready, done;

    logic        send8, abort8;
    logic [3:0]  padding8;
    logic [7:0]  packet8;
    logic        ready8, done8;

    node_port u_if ();
    node_port u8_if ();

    noc_serial_transmitter #(
        .PACKET_BITS (40),
        .PADDING_BITS(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .send   (send),
        .hdr    (hdr),
        .padding(padding),
        .packet (packet),
        .abort  (abort),
        .ready  (ready),
        .done   (done),
        .up     (u_if)
    );

    noc_serial_transmitter #(
        .PACKET_BITS (8),
        .PADDING_BITS(4)
    ) dut8 (
        .clk    (clk),
        .rst    (rst),
        .send   (send8),
        .hdr    (hdr),
        .padding(padding8),
        .packet (packet8),
        .abort  (abort8),
        .ready  (ready8),
        .done   (done8),
        .up     (u8_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int rx_count = 0;
    int exp_rx = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h",
                      name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [39:0] pkt;
        logic [3:0]  pad;
        logic [3:0]  dx;
        logic [3:0]  dy;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [47:0] asm_data;
    flit_hdr_t   asm_hdr;
    int          fidx = 0;
    flit_type_t  want_t;

    // Sink model: reassembles accepted flits and scores each packet.
    always @(negedge clk) begin
        if (rst || abort) begin
            if (!ready && sb.size() > 0) void'(sb.pop_front());
            fidx = 0;
        end else if (ready && send) begin
            sb.push_back('{packet, padding, hdr.dst_x, hdr.dst_y});
            fidx = 0;
        end else if (u_if.enable && u_if.ack && !u_if.rej) begin
            want_t = (fidx == 0)  ? FLIT_HEADER :
                     (fidx == NF) ? FLIT_TAIL : FLIT_DATA;
            chk("rx_type", 64'(u_if.flit.flit_type), 64'(want_t));
            if (fidx == 0) asm_hdr = u_if.flit.payload.hdr;
            else asm_data[(fidx-1)*16 +: 16] = u_if.flit.payload.data;
            if (fidx == NF) begin
                chk("sb_depth", 64'(sb.size()), 64'(1));
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("rx_packet", 64'(asm_data[39:0]), 64'(mon_e.pkt));
                    chk("rx_zext", 64'(asm_data[47:40]), 64'(0));
                    chk("rx_pad", 64'(asm_hdr.free), 64'(mon_e.pad));
                    chk("rx_dst", 64'({asm_hdr.dst_x, asm_hdr.dst_y}),
                        64'({mon_e.dx, mon_e.dy}));
                    rx_count++;
                end
                fidx = 0;
            end else begin
                fidx++;
            end
        end
    end

    task automatic start(input logic [39:0] p, input logic [3:0] pd,
                         input logic [3:0] dx, input logic [3:0] dy);
        for (int i = 0; i < 20 && !ready; i++) tick();
        chk("start_ready", 64'(ready), 64'(1));
        packet = p;
        padding = pd;
        hdr = '{dst_x: dx, dst_y: dy, free: 8'hEE};
        send = 1'b1;
        tick();
        send = 1'b0;
        packet = ~p;
        padding = ~pd;
        hdr = '{dst_x: ~dx, dst_y: ~dy, free: 8'h11};
    endtask

    task automatic wait_done(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            tick();
            if (done) break;
        end
        chk("wait_done", 64'(done), 64'(1));
    endtask

    typedef struct {
        logic [39:0] pkt;
        logic [3:0]  pad;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [7:0]  free;
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{40'h12_3456_789A, 4'hA, 4'h3, 4'h5,
                  16'h789A, 16'h3456, 16'h0012, 8'h0A};
        vt[1] = '{40'hFF_FFFF_FFFF, 4'hF, 4'hF, 4'h0,
                  16'hFFFF, 16'hFFFF, 16'h00FF, 8'h0F};
        vt[2] = '{40'h00_0000_0000, 4'h0, 4'h1, 4'h2,
                  16'h0000, 16'h0000, 16'h0000, 8'h00};
        vt[3] = '{40'hAB_CDEF_0123, 4'h5, 4'h7, 4'h9,
                  16'h0123, 16'hCDEF, 16'h00AB, 8'h05};

        rst = 1'b1; send = 1'b0; abort = 1'b0;
        packet = '0; padding = '0; hdr = '0;
        send8 = 1'b0; abort8 = 1'b0;
        packet8 = '0; padding8 = '0;
        u_if.ack = 1'b0; u_if.rej = 1'b0;
        u8_if.ack = 1'b0; u8_if.rej = 1'b0;
        tick();
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_enable", 64'(u_if.enable), 64'(0));
        chk("rst_flit", 64'(u_if.flit), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(ready), 64'(1));

        u_if.ack = 1'b1;
        foreach (vt[v]) begin
            start(vt[v].pkt, vt[v].pad, vt[v].dx, vt[v].dy);
            chk("v_hdr_type", 64'(u_if.flit.flit_type), 64'(FLIT_HEADER));
            chk("v_hdr_en", 64'(u_if.enable), 64'(1));
            chk("v_hdr_free", 64'(u_if.flit.payload.hdr.free),
                64'(vt[v].free));
            chk("v_hdr_dst", 64'({u_if.flit.payload.hdr.dst_x,
                                  u_if.flit.payload.hdr.dst_y}),
                64'({vt[v].dx, vt[v].dy}));
            chk("v_ready_busy", 64'(ready), 64'(0));
            tick();
            chk("v_d0", 64'(u_if.flit.payload.data), 64'(vt[v].s0));
            chk("v_d0_type", 64'(u_if.flit.flit_type), 64'(FLIT_DATA));
            tick();
            chk("v_d1", 64'(u_if.flit.payload.data), 64'(vt[v].s1));
            chk("v_d1_type", 64'(u_if.flit.flit_type), 64'(FLIT_DATA));
            tick();
            chk("v_tail", 64'(u_if.flit.payload.data), 64'(vt[v].s2));
            chk("v_tail_type", 64'(u_if.flit.flit_type), 64'(FLIT_TAIL));
            chk("v_tail_done", 64'(done), 64'(0));
            tick();
            chk("v_done", 64'(done), 64'(1));
            chk("v_done_ready", 64'(ready), 64'(1));
            chk("v_done_en", 64'(u_if.enable), 64'(0));
            tick();
            chk("v_done_pulse", 64'(done), 64'(0));
            exp_rx++;
        end

        // Backpressure on the second payload flit.
        start(40'h12_3456_789A, 4'hA, 4'h3, 4'h5);
        tick();
        tick();
        chk("bp_d1", 64'(u_if.flit.payload.data), 64'(16'h3456));
        for (int i = 0; i < 4; i++) begin
            u_if.ack = (i == 3);
            u_if.rej = (i == 3);
            tick();
            chk("bp_hold", 64'(u_if.flit.payload.data), 64'(16'h3456));
            chk("bp_hold_en", 64'(u_if.enable), 64'(1));
            chk("bp_no_done", 64'(done), 64'(0));
        end
        u_if.ack = 1'b1;
        u_if.rej = 1'b0;
        tick();
        chk("bp_tail", 64'(u_if.flit.flit_type), 64'(FLIT_TAIL));
        tick();
        chk("bp_done", 64'(done), 64'(1));
        exp_rx++;
        tick();

        // Abort on the first DATA cycle.
        start(40'h55_AAAA_5555, 4'h3, 4'h1, 4'h1);
        tick();
        chk("ab_d0_type", 64'(u_if.flit.flit_type), 64'(FLIT_DATA));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_enable", 64'(u_if.enable), 64'(0));
        chk("ab_ready", 64'(ready), 64'(1));
        chk("ab_done", 64'(done), 64'(0));
        tick();
        chk("ab_done2", 64'(done), 64'(0));
        start(40'h01_0203_0405, 4'h6, 4'h2, 4'h4);
        chk("ab_restart", 64'(u_if.flit.flit_type), 64'(FLIT_HEADER));
        wait_done(20);
        exp_rx++;
        tick();

        // Reset on the TAIL cycle.
        start(40'h99_8877_6655, 4'h9, 4'h8, 4'h7);
        tick();
        tick();
        tick();
        chk("rs_tail", 64'(u_if.flit.flit_type), 64'(FLIT_TAIL));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_enable", 64'(u_if.enable), 64'(0));
        chk("rs_flit", 64'(u_if.flit), 64'(0));
        chk("rs_done", 64'(done), 64'(0));
        chk("rs_ready", 64'(ready), 64'(1));
        tick();
        chk("rs_done2", 64'(done), 64'(0));

        // send held high: one idle cycle between packets.
        packet = 40'h0F_1E2D_3C4B;
        padding = 4'hC;
        hdr = '{dst_x: 4'h6, dst_y: 4'h6, free: 8'h00};
        send = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("b2b_enable", 64'(u_if.enable), 64'((i % 5) != 4));
        end
        send = 1'b0;
        exp_rx += 3;
        tick();

        // Single-flit payload.
        packet8 = 8'hC3;
        padding8 = 4'h6;
        u8_if.ack = 1'b1;
        send8 = 1'b1;
        tick();
        send8 = 1'b0;
        packet8 = 8'h00;
        chk("p8_hdr", 64'(u8_if.flit.flit_type), 64'(FLIT_HEADER));
        chk("p8_free", 64'(u8_if.flit.payload.hdr.free), 64'(8'h06));
        tick();
        chk("p8_tail", 64'(u8_if.flit.flit_type), 64'(FLIT_TAIL));
        chk("p8_data", 64'(u8_if.flit.payload.data), 64'(16'h00C3));
        tick();
        chk("p8_done", 64'(done8), 64'(1));
        chk("p8_ready", 64'(ready8), 64'(1));

        // Random loopback with random stalls and rejects.
        for (int n = 0; n < 50; n++) begin
            u_if.ack = 1'b1;
            u_if.rej = 1'b0;
            start({8'($urandom), 32'($urandom)}, 4'($urandom),
                  4'($urandom), 4'($urandom));
            for (int c = 0; c < 300; c++) begin
                u_if.ack = ($urandom_range(0, 3) != 0);
                u_if.rej = ($urandom_range(0, 7) == 0);
                tick();
                if (done) break;
            end
            chk("rnd_done", 64'(done), 64'(1));
            exp_rx++;
            u_if.ack = 1'b0;
            tick();
        end

        chk("rx_count", 64'(rx_count), 64'(exp_rx));
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
